mfp_ahb_reg_reader: RTL and testbench

- Read-side counterpart to the system's write-enabled registers.
- AHB-Lite read-only slave that returns NREGS 32-bit values from the `regs` bus to the MIPS core.
- Supports programmable wait states, a two-cycle ERROR response for bad addresses, and a per-register read strobe so sources can implement clear-on-read.
- Base-address decode is done upstream and arrives as HSEL.

---
 rtl/mfp_ahb_reg_reader_if.sv | 22 ++
 rtl/mfp_ahb_reg_reader.sv | 119 +++++++++++
 tb/tb_mfp_ahb_reg_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_reg_reader_if.sv
// AHB-Lite read-path signal bundle between the bus fabric (master side)
// and the register reader (slave side).
interface mfp_ahb_reg_reader_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/mfp_ahb_reg_reader.sv
// AHB-Lite read-only slave exposing NREGS 32-bit register values, with
// programmable wait states, a two-cycle ERROR response and per-register read strobes.
module mfp_ahb_reg_reader #(
  parameter int NREGS       = 4,
  parameter int ABITS       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  mfp_ahb_reg_reader_if.slave    bus,
  input  logic [32*NREGS-1:0]    regs,
  output logic [NREGS-1:0]       rd_strobe
);

  localparam int IDXW = ABITS - 2;
  localparam int NSLOT = 2 ** IDXW;
  localparam logic [IDXW:0] NREGS_W = (IDXW + 1)'(NREGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IDXW-1:0]   idx_q, idx_nxt;
  logic [31:0]       data_q, data_nxt;
  logic [NREGS-1:0]  strobe_nxt;

  logic [IDXW-1:0]   addr_idx;
  logic              accept;
  logic              bad;

  // Register file padded to the full decode window so any idx indexes in range.
  logic [31:0] reg_arr [NSLOT];
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NREGS) begin : g_live
      assign reg_arr[i] = regs[32*i +: 32];
    end else begin : g_pad
      assign reg_arr[i] = '0;
    end
  end

  function automatic logic [NREGS-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NREGS-1:0] r;
    r = '0;
    for (int k = 0; k < NREGS; k++) r[k] = (i == IDXW'(k));
    return r;
  endfunction

  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:ABITS], bus.HTRANS[0]};

  assign addr_idx = bus.HADDR[ABITS-1:2];
  assign accept   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign bad      = (bus.HADDR[1:0] != 2'b00) || ({1'b0, addr_idx} >= NREGS_W);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx_q;
    data_nxt   = data_q;
    strobe_nxt = '0;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept && !bus.HWRITE) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            data_nxt   = reg_arr[addr_idx];
            strobe_nxt = onehot(addr_idx);
          end else begin
            idx_nxt   = addr_idx;
            cnt_nxt   = 4'(WAIT_STATES - 1);
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          // Data is sampled at the completing edge so late source updates are seen.
          data_nxt   = reg_arr[idx_q];
          strobe_nxt = onehot(idx_q);
          state_nxt  = S_IDLE;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      data_q    <= '0;
      rd_strobe <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx_q     <= idx_nxt;
      data_q    <= data_nxt;
      rd_strobe <= strobe_nxt;
    end
  end

  assign bus.HRDATA    = data_q;
  assign bus.HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
  assign bus.HRESP     = (state == S_ERR1) || (state == S_ERR2);

endmodule

// File: tb/tb_mfp_ahb_reg_reader.sv
// Bench for mfp_ahb_reg_reader: three instances (0, 2 and 3 wait states) checked
// every cycle against a queue-of-response-beats model, plus hand-computed literals.
module tb_mfp_ahb_reg_reader;

  localparam int NI = 3;
  localparam int W_OF [NI] = '{0, 2, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] regs;
  logic         hsel   [NI];
  logic [1:0]   htrans [NI];
  logic         hwrite [NI];
  logic [31:0]  haddr  [NI];
  logic [31:0]  rdata  [NI];
  logic         rdy    [NI];
  logic         resp   [NI];
  logic [3:0]   strobe [NI];

  int n_chk = 0;
  int n_err = 0;

  mfp_ahb_reg_reader_if bus0 ();
  mfp_ahb_reg_reader_if bus1 ();
  mfp_ahb_reg_reader_if bus2 ();

  assign bus0.HSEL = hsel[0];  assign bus0.HTRANS = htrans[0];
  assign bus0.HWRITE = hwrite[0];  assign bus0.HADDR = haddr[0];
  assign bus0.HREADY = bus0.HREADYOUT;
  assign rdata[0] = bus0.HRDATA;  assign rdy[0] = bus0.HREADYOUT;  assign resp[0] = bus0.HRESP;

  assign bus1.HSEL = hsel[1];  assign bus1.HTRANS = htrans[1];
  assign bus1.HWRITE = hwrite[1];  assign bus1.HADDR = haddr[1];
  assign bus1.HREADY = bus1.HREADYOUT;
  assign rdata[1] = bus1.HRDATA;  assign rdy[1] = bus1.HREADYOUT;  assign resp[1] = bus1.HRESP;

  assign bus2.HSEL = hsel[2];  assign bus2.HTRANS = htrans[2];
  assign bus2.HWRITE = hwrite[2];  assign bus2.HADDR = haddr[2];
  assign bus2.HREADY = bus2.HREADYOUT;
  assign rdata[2] = bus2.HRDATA;  assign rdy[2] = bus2.HREADYOUT;  assign resp[2] = bus2.HRESP;

  mfp_ahb_reg_reader #(.NREGS(4), .ABITS(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .regs(regs), .rd_strobe(strobe[0]));
  mfp_ahb_reg_reader #(.NREGS(4), .ABITS(8), .WAIT_STATES(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .regs(regs), .rd_strobe(strobe[1]));
  mfp_ahb_reg_reader #(.NREGS(4), .ABITS(8), .WAIT_STATES(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .regs(regs), .rd_strobe(strobe[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted transfer becomes a list of response beats, one per cycle.
  typedef struct packed {
    logic       ready;
    logic       resp;
    logic       has_data;
    logic [1:0] idx;
  } beat_t;

  localparam beat_t IDLE_BEAT  = '{ready: 1'b1, resp: 1'b0, has_data: 1'b0, idx: 2'd0};
  localparam beat_t STALL_BEAT = '{ready: 1'b0, resp: 1'b0, has_data: 1'b0, idx: 2'd0};
  localparam beat_t ERR1_BEAT  = '{ready: 1'b0, resp: 1'b1, has_data: 1'b0, idx: 2'd0};
  localparam beat_t ERR2_BEAT  = '{ready: 1'b1, resp: 1'b1, has_data: 1'b0, idx: 2'd0};

  beat_t       fifo [NI][32];
  int          rp [NI];
  int          wp [NI];
  beat_t       cur [NI];
  logic [31:0] m_data [NI];
  logic [3:0]  m_strobe [NI];

  function automatic void push(input int k, input beat_t b);
    fifo[k][wp[k] % 32] = b;
    wp[k]++;
  endfunction

  function automatic logic [31:0] word(input int i);
    return regs[32*i +: 32];
  endfunction

  always @(posedge clk or negedge rst) begin
    int a;
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        cur[k] = IDLE_BEAT;  rp[k] = 0;  wp[k] = 0;
        m_data[k] = '0;  m_strobe[k] = '0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (hsel[k] && htrans[k][1] && cur[k].ready && !hwrite[k]) begin
          a = int'(haddr[k] % 256);
          if (a % 4 != 0 || a / 4 >= 4) begin
            push(k, ERR1_BEAT);
            push(k, ERR2_BEAT);
          end else begin
            for (int s = 0; s < W_OF[k]; s++) push(k, STALL_BEAT);
            push(k, '{ready: 1'b1, resp: 1'b0, has_data: 1'b1, idx: 2'(a / 4)});
          end
        end
        if (rp[k] != wp[k]) begin
          cur[k] = fifo[k][rp[k] % 32];
          rp[k]++;
        end else begin
          cur[k] = IDLE_BEAT;
        end
        m_strobe[k] = cur[k].has_data ? (4'b0001 << cur[k].idx) : 4'b0000;
        if (cur[k].has_data) m_data[k] = word(int'(cur[k].idx));
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      check($sformatf("i%0d_hrdata", k), rdata[k], m_data[k]);
      check($sformatf("i%0d_hreadyout", k), 32'(rdy[k]), 32'(cur[k].ready));
      check($sformatf("i%0d_hresp", k), 32'(resp[k]), 32'(cur[k].resp));
      check($sformatf("i%0d_strobe", k), 32'(strobe[k]), 32'(m_strobe[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input int k, input logic [31:0] a);
    hsel[k] = 1'b1;  htrans[k] = 2'b10;  hwrite[k] = 1'b0;  haddr[k] = a;
  endtask

  task automatic set_wr(input int k, input logic [31:0] a);
    hsel[k] = 1'b1;  htrans[k] = 2'b10;  hwrite[k] = 1'b1;  haddr[k] = a;
  endtask

  task automatic set_idle(input int k);
    hsel[k] = 1'b0;  htrans[k] = 2'b00;  hwrite[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      set_idle(k);
      haddr[k] = '0;
    end
    regs = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    #1 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("idle_data", rdata[0], 32'h0);
    check("idle_ready", 32'(rdy[0]), 32'h1);
    check("idle_resp", 32'(resp[0]), 32'h0);
    check("idle_strobe", 32'(strobe[0]), 32'h0);

    // Back-to-back reads with no wait states
    set_rd(0, 32'h04);
    tick();
    check("b2b_data0", rdata[0], 32'hBBBB0001);
    check("b2b_strobe0", 32'(strobe[0]), 32'h2);
    set_rd(0, 32'h0C);
    tick();
    check("b2b_data1", rdata[0], 32'hDDDD0003);
    check("b2b_strobe1", 32'(strobe[0]), 32'h8);
    check("b2b_ready", 32'(rdy[0]), 32'h1);
    set_idle(0);
    tick();
    check("b2b_strobe_clr", 32'(strobe[0]), 32'h0);

    // Two wait states; source changes during the first wait cycle, HSEL held
    set_rd(1, 32'h08);
    tick();
    regs[95:64] = 32'h12345678;
    check("w2_stall1", 32'(rdy[1]), 32'h0);
    tick();
    check("w2_stall2", 32'(rdy[1]), 32'h0);
    set_idle(1);
    tick();
    check("w2_ready", 32'(rdy[1]), 32'h1);
    check("w2_data", rdata[1], 32'h12345678);
    check("w2_strobe", 32'(strobe[1]), 32'h4);
    tick();
    check("w2_strobe_clr", 32'(strobe[1]), 32'h0);

    // Out-of-range address
    set_rd(0, 32'h10);
    tick();
    check("err_range_p1", {30'd0, rdy[0], resp[0]}, 32'h1);
    set_idle(0);
    tick();
    check("err_range_p2", {30'd0, rdy[0], resp[0]}, 32'h3);
    tick();
    check("err_range_idle", {30'd0, rdy[0], resp[0]}, 32'h2);
    check("err_range_data", rdata[0], 32'hDDDD0003);

    // Unaligned address, then a read accepted during the second error cycle
    set_rd(0, 32'h06);
    tick();
    check("err_unal_p1", {30'd0, rdy[0], resp[0]}, 32'h1);
    check("err_unal_strobe", 32'(strobe[0]), 32'h0);
    set_idle(0);
    tick();
    check("err_unal_p2", {30'd0, rdy[0], resp[0]}, 32'h3);
    set_rd(0, 32'h00);
    tick();
    check("err2_accept_data", rdata[0], 32'hAAAA0000);
    check("err2_accept_strobe", 32'(strobe[0]), 32'h1);
    set_idle(0);
    tick();

    // Write is an OKAY no-op
    set_wr(0, 32'h00);
    tick();
    check("wr_resp", {30'd0, rdy[0], resp[0]}, 32'h2);
    check("wr_data", rdata[0], 32'hAAAA0000);
    check("wr_strobe", 32'(strobe[0]), 32'h0);
    set_idle(0);
    tick();

    // Three wait states: a normal read, then reset inside the second wait cycle
    set_rd(2, 32'h04);
    tick();
    set_idle(2);
    repeat (3) tick();
    check("w3_data", rdata[2], 32'hBBBB0001);
    check("w3_strobe", 32'(strobe[2]), 32'h2);
    tick();
    set_rd(2, 32'h0C);
    tick();
    set_idle(2);
    tick();
    check("w3_stall2", 32'(rdy[2]), 32'h0);
    #1 rst = 1'b0;
    #1;
    check("rst_async_ready", 32'(rdy[2]), 32'h1);
    check("rst_async_data", rdata[2], 32'h0);
    check("rst_async_strobe", 32'(strobe[2]), 32'h0);
    #3 rst = 1'b1;
    tick();
    check("rst_after_strobe", 32'(strobe[2]), 32'h0);
    check("rst_after_data", rdata[2], 32'h0);
    set_rd(2, 32'h00);
    tick();
    set_idle(2);
    repeat (3) tick();
    check("post_rst_data", rdata[2], 32'hAAAA0000);
    check("post_rst_strobe", 32'(strobe[2]), 32'h1);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
